pf_rom_arbiter: RTL
===================

# pf_rom_arbiter

Shares one synchronous playfield tile ROM port (11-bit address, 8-bit data, one-clock registered read) among three requesters: the two playfield fetch engines (pf0, pf1) and a low-priority CPU readback port. It sits between the playfield fetch logic and a single `pf_rom` instance. It grants at most one read per clock and tags the returned byte back to the requester that issued it. A starvation counter bounds CPU wait time while the playfields are streaming.

## Interface
Parameters:
- `AW`, 11, ROM address width
- `DW`, 8, ROM data width
- `STARVE`, 15, CPU wait cycles before forced grant (range 1..255)

Ports:
- `clk`  in  1  single system clock; all logic on posedge
- `reset`  in  1  synchronous, active-high reset
- `req0`  in  1  pf0 read request
- `addr0`  in  AW  pf0 address, held while req0 high and ack0 low
- `ack0`  out  1  pf0 grant pulse
- `valid0`  out  1  pf0 data valid
- `data0`  out  DW  pf0 read data; meaningful only when valid0 is high
- `req1`, `addr1`, `ack1`, `valid1`, `data1`  same for pf1
- `cpu_req`, `cpu_addr`, `cpu_ack`, `cpu_valid`, `cpu_data`  same for the CPU port
- `rom_a`  out  AW  address to the ROM, registered
- `rom_d`  in  DW  ROM data, registered inside the ROM one clock after rom_a

## Operation
- **Arbitration decision, every clock edge.** Made from the current req0, req1 and cpu_req; the winner is picked in this order:
  - `starve_cnt == STARVE` and cpu_req high: CPU wins.
  - Both pf requests high: the pf not granted last wins. The 1-bit `last_pf` pointer toggles on each pf grant.
  - Exactly one pf request high: that pf wins.
  - No pf request and cpu_req high: CPU wins.
  - Otherwise: idle.
- **Grant.** At the edge:
  - `rom_a` loads the winner's address.
  - The winner's `ackN` goes high for the following cycle only.
  - A 2-bit grant tag (none/pf0/pf1/cpu) is registered.
- **Idle.** No ack is issued and `rom_a` holds its previous value.
- **Return.** One edge later the tag moves to a second stage, and the matching `validN` is high for one cycle.
  - All `dataN` outputs are driven directly from `rom_d`.
- **Starvation counter (8-bit).**
  - Increments, saturating at STARVE, on each edge where cpu_req is high and the CPU is not granted.
  - Clears on a CPU grant, and whenever cpu_req is low.
- **Requester rule.** A request still high during its ack cycle counts as a new request: same address means a repeated read, a new address means the next read. This gives one read per clock per requester when uncontested.

## Timing
- **Reset.** The following take these values in the cycle after reset is asserted, and hold while reset stays high:
  - ack0, ack1, cpu_ack, valid0, valid1, cpu_valid all = 0.
  - rom_a = 0.
  - Tags = none.
  - last_pf = pf1, so pf0 wins the first contest.
  - starve_cnt = 0.
- **Reset mid-operation.** In-flight tags are discarded; no valid is issued for a read granted before reset.
- **Latency.** Request sampled at edge E0 gives ack high in cycle E0+1. rom_d and validN are high in cycle E1+1, i.e. valid is exactly one cycle after ack.
- **Throughput.** One grant per cycle total; the pipeline is never stalled.
- **Simultaneous events.**
  - pf0+pf1+cpu requesting with starve_cnt < STARVE: pf0 and pf1 alternate and starve_cnt counts.
  - At STARVE the CPU takes exactly one slot. The pf pointer is unchanged, so the pf due next wins the following cycle.
- **Request drop.** Dropping a request before its ack cancels it. No ack or valid is issued for it and no state changes, except that starve_cnt clears if it is the CPU request.
- **At most one ack and at most one valid** are high in any cycle.

## Test plan
- **Reset check:** hold reset 3 cycles with all req high → every ack/valid is 0 and rom_a = 0. Release reset → pf0 is acked first; rom_a = addr0 one cycle after release.
- **Single pf0 read:** addr0 = 0x123, req0 for one cycle, ROM preloaded with 0x5A at 0x123 → ack0 one cycle later, then valid0 with data0 = 0x5A; no other ack or valid.
- **pf contest:** req0 and req1 high for 6 cycles, distinct addresses → acks alternate 0,1,0,1,0,1; each valid lags its ack by one cycle with the correct data.
- **CPU starvation:** STARVE = 4; req0, req1 and cpu_req held high → cpu_ack after 4 denied cycles, then pf alternation resumes with the pf due next. Repeats every 5 grants.
- **CPU idle path:** only cpu_req high, cpu_addr = 0x7FF → cpu_ack next cycle, cpu_valid with the ROM byte at 0x7FF; starve_cnt stays 0.
- **Reset in flight:** grant pf1, then assert reset in its ack cycle → valid1 never asserts; after release, arbitration restarts with pf0 priority.

Source files
------------

// File: rtl/pf_rom_arbiter.sv
// pf_rom_arbiter: shares one registered-read tile ROM port among pf0, pf1 and a low-priority CPU,
// tagging each granted read so its byte returns to the requester that issued it.
module pf_rom_arbiter #(
    parameter int AW = 11,
    parameter int DW = 8,
    parameter int STARVE = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    output logic          ack0,
    output logic          valid0,
    output logic [DW-1:0] data0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    output logic          ack1,
    output logic          valid1,
    output logic [DW-1:0] data1,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_ack,
    output logic          cpu_valid,
    output logic [DW-1:0] cpu_data,
    output logic [AW-1:0] rom_a,
    input  logic [DW-1:0] rom_d
);
    typedef enum logic [1:0] {T_NONE, T_PF0, T_PF1, T_CPU} tag_t;
    tag_t          win, tag_a, tag_v;
    logic          last_pf;
    logic          starved;
    logic [7:0]    starve_cnt;
    logic [AW-1:0] win_addr;
    // last_pf = 1 means pf1 was the most recent pf grant
    always_comb begin
        starved  = cpu_req && (starve_cnt == 8'(STARVE));
        win      = starved ? T_CPU :
                   (req0 && req1) ? (last_pf ? T_PF0 : T_PF1) :
                   req0 ? T_PF0 :
                   req1 ? T_PF1 :
                   cpu_req ? T_CPU : T_NONE;
        win_addr = (win == T_PF0) ? addr0 : (win == T_PF1) ? addr1 : cpu_addr;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_a      <= T_NONE;
            tag_v      <= T_NONE;
            rom_a      <= '0;
            last_pf    <= 1'b1;
            starve_cnt <= '0;
        end else begin
            tag_a <= win;
            tag_v <= tag_a;
            if (win != T_NONE) rom_a <= win_addr;
            if (win == T_PF0 || win == T_PF1) last_pf <= (win == T_PF1);
            starve_cnt <= (!cpu_req || win == T_CPU) ? 8'd0 :
                          starved ? starve_cnt : starve_cnt + 8'd1;
        end
    end
    assign ack0      = (tag_a == T_PF0);
    assign ack1      = (tag_a == T_PF1);
    assign cpu_ack   = (tag_a == T_CPU);
    assign valid0    = (tag_v == T_PF0);
    assign valid1    = (tag_v == T_PF1);
    assign cpu_valid = (tag_v == T_CPU);
    assign data0     = rom_d;
    assign data1     = rom_d;
    assign cpu_data  = rom_d;
endmodule
